cache_line_reg_pos: RTL

Parametrised cache-line storage register, the successor to the fixed 8-bit decoder-selected register.
- Holds one DATA_W-bit line with per-byte write enables.
- Keeps valid and dirty status bits.
- Keeps a saturating age counter used by the set's replacement logic.
- One instance per way/line. The set's decoder drives decOut1b; the shared cache controller drives all other controls.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_line_reg_pos_chk.sv | 31 +++
 rtl/register_byte_pos.sv | 31 +++
 rtl/cache_line_reg_pos.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants for the cache-line storage register.
//   BYTE_W      : width of one byte lane
//   DATA_W_DEF  : default line width in bits
//   AGE_W_DEF   : default age counter width in bits
//   NBYTES      : byte lanes in a default-width line
//   nbytes_of() : byte lanes in a line of arbitrary width
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int BYTE_W     = 8;
    localparam int DATA_W_DEF = 32;
    localparam int AGE_W_DEF  = 2;
    localparam int NBYTES     = DATA_W_DEF / BYTE_W;

    function automatic int nbytes_of(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/cache_line_reg_pos_chk.sv
// -----------------------------------------------------------------------------
// cache_line_reg_pos_chk
// Simulation-only consistency checks for cache_line_reg_pos.
//   clk   : clock
//   reset : synchronous active-high reset of the checked line
//   valid : line valid flag
//   dirty : line dirty flag
// -----------------------------------------------------------------------------
module cache_line_reg_pos_chk #(
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset,
    input logic valid,
    input logic dirty
);

    // The line is built from whole byte lanes.
    if ((DATA_W % 8) != 0) begin : g_bad_width
        $error("cache_line_reg_pos: DATA_W=%0d is not a multiple of 8", DATA_W);
    end

    if ((DATA_W < 8) || (DATA_W > 256)) begin : g_bad_range
        $error("cache_line_reg_pos: DATA_W=%0d outside 8..256", DATA_W);
    end

    // A line can only become dirty after it was filled.
    a_dirty_implies_valid : assert property (@(posedge clk) disable iff (reset)
        dirty |-> valid);

endmodule

// File: rtl/register_byte_pos.sv
// -----------------------------------------------------------------------------
// register_byte_pos
// One 8-bit byte lane of a cache line: synchronous clear plus load enable.
//   clk   : clock
//   reset : synchronous active-high clear (overrides en)
//   en    : load d on the rising edge
//   d     : byte to load
//   q     : registered byte
// -----------------------------------------------------------------------------
module register_byte_pos
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] q
);

    // Byte storage: clear wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {BYTE_W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/cache_line_reg_pos.sv
// -----------------------------------------------------------------------------
// cache_line_reg_pos
// One cache line (way) of a set: data bytes, valid/dirty status and a
// saturating age counter for replacement.
//   clk        : clock, all state updates on rising edge
//   reset      : synchronous active-high, clears all state
//   regWrite   : CPU store hit (byte-masked by byteEn, only on a valid line)
//   decOut1b   : line select from the set decoder
//   fill       : whole-line fill from next level
//   invalidate : invalidate selected line (data retained)
//   access     : set lookup strobe, drives the age update
//   byteEn     : per-byte write enables for regWrite
//   inpData    : write / fill data
//   outData    : registered line contents
//   valid      : line holds valid data
//   dirty      : line modified since fill
//   age        : set accesses since this line was last used (saturating)
// -----------------------------------------------------------------------------
module cache_line_reg_pos
    import cache_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AGE_W  = AGE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     regWrite,
    input  logic                     decOut1b,
    input  logic                     fill,
    input  logic                     invalidate,
    input  logic                     access,
    input  logic [DATA_W/BYTE_W-1:0] byteEn,
    input  logic [DATA_W-1:0]        inpData,
    output logic [DATA_W-1:0]        outData,
    output logic                     valid,
    output logic                     dirty,
    output logic [AGE_W-1:0]         age
);

    localparam int              LINE_BYTES = nbytes_of(DATA_W);
    localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};

    logic                  inv_win;
    logic                  fill_win;
    logic                  write_win;
    logic [LINE_BYTES-1:0] byte_en;

    // Request arbitration: invalidate > fill > regWrite, all gated by the
    // line select. A store to an invalid line is dropped outright.
    always_comb begin
        inv_win   = 1'b0;
        fill_win  = 1'b0;
        write_win = 1'b0;
        if (decOut1b) begin
            inv_win   = invalidate;
            fill_win  = fill & ~invalidate;
            write_win = regWrite & ~fill & ~invalidate & valid;
        end else begin
            inv_win   = 1'b0;
            fill_win  = 1'b0;
            write_win = 1'b0;
        end
    end

    // Per-lane load enables: fill loads every lane, a store only its masked lanes.
    always_comb begin
        byte_en = {LINE_BYTES{1'b0}};
        for (int i = 0; i < LINE_BYTES; i++) begin
            byte_en[i] = reset | (decOut1b & (fill_win | (write_win & byteEn[i])));
        end
    end

    for (genvar g = 0; g < LINE_BYTES; g++) begin : g_byte
        register_byte_pos u_byte (
            .clk   (clk),
            .reset (reset),
            .en    (byte_en[g]),
            .d     (inpData[g*BYTE_W +: BYTE_W]),
            .q     (outData[g*BYTE_W +: BYTE_W])
        );
    end

    // Status bits and age counter. Invalidate and fill own the cycle; otherwise
    // a store may set dirty and an access updates age independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            dirty <= 1'b0;
            age   <= {AGE_W{1'b0}};
        end else if (inv_win) begin
            valid <= 1'b0;
            dirty <= 1'b0;
            age   <= {AGE_W{1'b0}};
        end else if (fill_win) begin
            valid <= 1'b1;
            dirty <= 1'b0;
            age   <= {AGE_W{1'b0}};
        end else begin
            valid <= valid;
            if (write_win && (|byteEn)) begin
                dirty <= 1'b1;
            end else begin
                dirty <= dirty;
            end
            if (access && valid) begin
                if (decOut1b) begin
                    age <= {AGE_W{1'b0}};
                end else if (age != AGE_MAX) begin
                    age <= age + AGE_W'(1);
                end else begin
                    age <= age;
                end
            end else begin
                age <= age;
            end
        end
    end

    cache_line_reg_pos_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .dirty (dirty)
    );

endmodule
